key_map_ram: RTL

Clocked, parametrised successor to the note-key remapping store. It holds PROFILES independent tables of KEY_BITS one-hot entries, each mapping a physical key to the note key it plays. It adds a synchronous registered read, a one-hot validity check, per-profile restore-to-identity and a two-key "learn" sequencer that rebinds keys straight from the keyboard. It sits between the keyboard debouncer and the note decoder/player.

---
 rtl/key_map_ram_pkg.sv | 22 ++
 rtl/key_map_ram_onehot_index.sv | 26 ++
 rtl/key_map_ram.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/key_map_ram_pkg.sv
// key_map_ram_pkg
// Shared constants and types for the note-key remapping store.
//   NOTE_KEY_BITS : number of physical/note keys (entry width and entry count)
//   km_state_e    : learn sequencer state encoding
//   idx_width()   : index width for a one-hot vector of n bits (never below 1)
package key_map_ram_pkg;

    localparam int NOTE_KEY_BITS = 7;

    typedef enum logic [2:0] {
        KM_IDLE   = 3'd0,
        KM_SRC    = 3'd1,
        KM_REL    = 3'd2,
        KM_DST    = 3'd3,
        KM_COMMIT = 3'd4
    } km_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_map_ram_onehot_index.sv
// key_map_ram_onehot_index
// Converts a one-hot vector into the position of its set bit.
//   vec   : input vector, W bits
//   idx   : position of the set bit (meaningful only when valid)
//   valid : exactly one bit of vec is set
module key_map_ram_onehot_index
    import key_map_ram_pkg::*;
#(
    parameter int W  = NOTE_KEY_BITS,
    parameter int IW = idx_width(W)
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (vec[i]) idx = IW'(i);
        end
        // Clearing the lowest set bit leaves zero only for a single-bit vector.
        valid = (vec != '0) && ((vec & (vec - W'(1))) == '0);
    end

endmodule

// File: rtl/key_map_ram.sv
// key_map_ram
// Per-profile key remapping tables with registered read, one-hot address
// checking, restore-to-identity and a two-key learn sequencer.
//   clk, rst_n   : clock, synchronous active-low reset
//   prof_sel     : active profile for read, write, learn and restore
//   wr_en/wr_addr/wr_data : external write (one-hot address)
//   rd_addr/rd_data       : one-hot lookup, result registered
//   restore      : reload active profile with identity
//   learn_start  : begin learn; key_in supplies source then destination key
//   learn_busy   : learn sequencer not idle
//   learn_done   : one-cycle pulse after a learn commit
//   addr_err     : one-cycle pulse for an invalid one-hot address on an active access
//
// state     | meaning
// ----------+---------------------------------------------------------
// KM_IDLE   | waiting for learn_start
// KM_SRC    | waiting for a single pressed key (source entry)
// KM_REL    | waiting for all keys released
// KM_DST    | waiting for a single pressed key (destination value)
// KM_COMMIT | write dst into src entry of the active profile
module key_map_ram
    import key_map_ram_pkg::*;
#(
    parameter int KEY_BITS = NOTE_KEY_BITS,
    parameter int PROFILES = 2,
    parameter int PW       = idx_width(PROFILES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PW-1:0]       prof_sel,
    input  logic                wr_en,
    input  logic [KEY_BITS-1:0] wr_addr,
    input  logic [KEY_BITS-1:0] wr_data,
    input  logic [KEY_BITS-1:0] rd_addr,
    output logic [KEY_BITS-1:0] rd_data,
    input  logic                restore,
    input  logic                learn_start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                learn_busy,
    output logic                learn_done,
    output logic                addr_err
);

    localparam int                  IW       = idx_width(KEY_BITS);
    localparam logic [KEY_BITS-1:0] ONE      = KEY_BITS'(1);
    localparam logic [PW:0]         PROF_LIM = (PW+1)'(PROFILES);

    logic [KEY_BITS-1:0] tbl [PROFILES][KEY_BITS];

    logic [IW-1:0]       rd_idx, wr_idx, key_idx;
    logic                rd_ok, wr_ok, key_ok;
    logic                prof_ok;
    logic                wr_act;
    logic                commit;

    km_state_e           state_q, state_d;
    logic                src_ld, dst_ld;
    logic [IW-1:0]       src_idx_q;
    logic [KEY_BITS-1:0] dst_q;

    key_map_ram_onehot_index #(.W(KEY_BITS), .IW(IW)) u_rd_idx (
        .vec   (rd_addr),
        .idx   (rd_idx),
        .valid (rd_ok)
    );

    key_map_ram_onehot_index #(.W(KEY_BITS), .IW(IW)) u_wr_idx (
        .vec   (wr_addr),
        .idx   (wr_idx),
        .valid (wr_ok)
    );

    key_map_ram_onehot_index #(.W(KEY_BITS), .IW(IW)) u_key_idx (
        .vec   (key_in),
        .idx   (key_idx),
        .valid (key_ok)
    );

    // A non-power-of-two profile count leaves unused prof_sel codes; those
    // read as zero and never modify storage.
    assign prof_ok    = ({1'b0, prof_sel} < PROF_LIM);
    assign learn_busy = (state_q != KM_IDLE);
    assign commit     = (state_q == KM_COMMIT) && !restore;
    // External writes are locked out while learning and lose to restore;
    // a locked-out write is not an access, so it cannot raise addr_err.
    assign wr_act     = wr_en && !learn_busy && !restore;

    always_comb begin
        state_d = state_q;
        src_ld  = 1'b0;
        dst_ld  = 1'b0;
        case (state_q)
            KM_IDLE:   if (learn_start) state_d = KM_SRC;
            KM_SRC:    if (key_ok) begin
                           src_ld  = 1'b1;
                           state_d = KM_REL;
                       end
            KM_REL:    if (key_in == '0) state_d = KM_DST;
            KM_DST:    if (key_ok) begin
                           dst_ld  = 1'b1;
                           state_d = KM_COMMIT;
                       end
            KM_COMMIT: state_d = KM_IDLE;
            default:   state_d = KM_IDLE;
        endcase
        if (restore) begin
            state_d = KM_IDLE;
            src_ld  = 1'b0;
            dst_ld  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= KM_IDLE;
            src_idx_q  <= '0;
            dst_q      <= '0;
            rd_data    <= '0;
            learn_done <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (src_ld) src_idx_q <= key_idx;
            if (dst_ld) dst_q     <= key_in;
            // Reads sample storage before this edge's update: read-first.
            rd_data    <= (rd_ok && prof_ok) ? tbl[prof_sel][rd_idx] : '0;
            learn_done <= commit;
            addr_err   <= !rd_ok || (wr_act && !wr_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < PROFILES; p++) begin
                for (int i = 0; i < KEY_BITS; i++) begin
                    tbl[p][i] <= ONE << i;
                end
            end
        end else if (restore) begin
            if (prof_ok) begin
                for (int i = 0; i < KEY_BITS; i++) begin
                    tbl[prof_sel][i] <= ONE << i;
                end
            end
        end else if (commit) begin
            if (prof_ok) tbl[prof_sel][src_idx_q] <= dst_q;
        end else if (wr_act && wr_ok && prof_ok) begin
            tbl[prof_sel][wr_idx] <= wr_data;
        end
    end

endmodule
